// File: rtl/avalon_burst_master.sv
// avalon_burst_master
//   Avalon-MM burst master. Accepts one read or write command at a time and
//   issues it as a single burst of up to MAX_BURST beats, streaming write data
//   in from wr_* and read data out on rd_*.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   avm_m0_*                Avalon-MM master port (address, read, write,
//                           writedata, byteenable, burstcount, waitrequest,
//                           readdata, readdatavalid)
//   cmd_valid/cmd_ready     command handshake; cmd_write, cmd_address, cmd_len
//   wr_data/wr_valid/wr_ready  write beat stream (wr_ready is combinational)
//   rd_data/rd_valid        read beat stream, no backpressure
//   done                    one-cycle pulse at command completion
//   busy                    high from the cycle after accept until done
module avalon_burst_master #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 64,
    parameter int BCW       = $clog2(MAX_BURST) + 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic [ADDR_W-1:0]   avm_m0_address,
    output logic                avm_m0_read,
    output logic                avm_m0_write,
    output logic [DATA_W-1:0]   avm_m0_writedata,
    output logic [DATA_W/8-1:0] avm_m0_byteenable,
    output logic [BCW-1:0]      avm_m0_burstcount,
    input  logic                avm_m0_waitrequest,
    input  logic [DATA_W-1:0]   avm_m0_readdata,
    input  logic                avm_m0_readdatavalid,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_address,
    input  logic [BCW-1:0]      cmd_len,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                done,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_REQ, RD_DATA} state_t;

    localparam logic [BCW-1:0] MAX_LEN = BCW'(MAX_BURST);
    localparam logic [BCW-1:0] ONE     = BCW'(1);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BCW-1:0]      bcount_q;
    logic [BCW-1:0]      cnt_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                done_q;
    logic                busy_q;

    logic [BCW-1:0]      len_d;
    logic                wr_beat;
    logic                last_beat;

    // Oversize requests are clamped rather than rejected.
    assign len_d     = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    assign wr_beat   = (state_q == WR_BURST) && wr_valid && !avm_m0_waitrequest;
    assign last_beat = (cnt_q == ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            bcount_q   <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (len_d == '0) begin
                            // Zero-length command completes without touching the bus.
                            done_q <= 1'b1;
                        end else begin
                            addr_q   <= cmd_address;
                            bcount_q <= len_d;
                            cnt_q    <= len_d;
                            busy_q   <= 1'b1;
                            state_q  <= cmd_write ? WR_BURST : RD_REQ;
                        end
                    end
                end
                WR_BURST: begin
                    if (wr_beat) begin
                        cnt_q <= cnt_q - ONE;
                        if (last_beat) begin
                            state_q  <= IDLE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            addr_q   <= '0;
                            bcount_q <= '0;
                        end
                    end
                end
                RD_REQ: begin
                    if (!avm_m0_waitrequest) begin
                        state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (avm_m0_readdatavalid) begin
                        rd_data_q  <= avm_m0_readdata;
                        rd_valid_q <= 1'b1;
                        cnt_q      <= cnt_q - ONE;
                        if (last_beat) begin
                            // done lands in the same cycle as the final rd_valid.
                            state_q  <= IDLE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            addr_q   <= '0;
                            bcount_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready         = (state_q == IDLE);
    assign avm_m0_address    = addr_q;
    assign avm_m0_burstcount = bcount_q;
    assign avm_m0_read       = (state_q == RD_REQ);
    assign avm_m0_write      = (state_q == WR_BURST) && wr_valid;
    assign avm_m0_writedata  = (state_q == WR_BURST) ? wr_data : '0;
    assign avm_m0_byteenable = ((state_q == WR_BURST) || (state_q == RD_REQ)) ? '1 : '0;
    // Combinational so a stalled beat is held by the producer in the same cycle.
    assign wr_ready          = (state_q == WR_BURST) && !avm_m0_waitrequest;
    assign rd_data           = rd_data_q;
    assign rd_valid          = rd_valid_q;
    assign done              = done_q;
    assign busy              = busy_q;

endmodule

// File: doc/avalon_burst_master.md
# avalon_burst_master

Parametrised Avalon-MM master between the canny pipeline and the DDR3 port of the HPS/VFB fabric. It accepts one command at a time: a read or write of `cmd_len` consecutive beats starting at a byte address. Each command is issued as a single Avalon burst, with per-beat write-data and read-data streaming. It replaces single-beat access with full-width burst transfers and streaming handshakes.

## Interface
**Parameters**
- `DATA_W`, 128: data width in bits; must be a multiple of 8.
- `ADDR_W`, 32: byte address width.
- `MAX_BURST`, 64: maximum beats per command; must be a power of 2 and ≤ 64.
- `BCW`, `$clog2(MAX_BURST)+1`: width of burstcount and `cmd_len` (7 by default).

**Ports**
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `avm_m0_address` out `ADDR_W`: burst start byte address.
- `avm_m0_read` out 1: read request.
- `avm_m0_write` out 1: write beat valid.
- `avm_m0_writedata` out `DATA_W`: write beat data.
- `avm_m0_byteenable` out `DATA_W/8`: byte enables.
- `avm_m0_burstcount` out `BCW`: beats in the burst.
- `avm_m0_waitrequest` in 1: slave stall.
- `avm_m0_readdata` in `DATA_W`: read beat data.
- `avm_m0_readdatavalid` in 1: read beat valid.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_address` in `ADDR_W`: start byte address; must be `DATA_W/8`-aligned.
- `cmd_len` in `BCW`: beat count.
- `wr_data` in `DATA_W`: write stream data.
- `wr_valid` in 1: write stream valid.
- `wr_ready` out 1: write beat consumed.
- `rd_data` out `DATA_W`: read stream data.
- `rd_valid` out 1: read beat valid. There is no backpressure; the consumer must take every beat.
- `done` out 1: one-cycle pulse when the command completes.
- `busy` out 1: high from command accept until `done`.

## Operation
- The FSM has four states: IDLE, WR_BURST, RD_REQ, RD_DATA.
- `cmd_ready` = (state == IDLE).
- On accept, the block registers `cmd_address`, `cmd_write`, and the effective length `len`:
  - `len` = min(`cmd_len`, `MAX_BURST`).
  - `cmd_len` = 0: no bus activity; `done` pulses next cycle; state stays IDLE.
  - Otherwise: a write goes to WR_BURST and a read goes to RD_REQ. The beat counter loads `len`.
- `avm_m0_address` and `avm_m0_burstcount` hold the registered values for the whole burst. Both are 0 in IDLE.
- `avm_m0_byteenable` is all ones in WR_BURST and RD_REQ, and 0 otherwise.

**WR_BURST**
- `avm_m0_write` = `wr_valid`.
- `avm_m0_writedata` = `wr_data`.
- `wr_ready` = !`avm_m0_waitrequest`. The path is combinational.
- A beat transfers when `avm_m0_write` is high and `avm_m0_waitrequest` is low; the counter decrements.
- The last beat transfers → state goes to IDLE and `done` pulses the next cycle.
- A `wr_valid` low gap deasserts `avm_m0_write`. This is legal mid-burst; address and burstcount stay held.

**RD_REQ**
- `avm_m0_read` = 1 until a cycle with `avm_m0_waitrequest` low, then state goes to RD_DATA.

**RD_DATA**
- Each `avm_m0_readdatavalid` registers `avm_m0_readdata` into `rd_data`, raises `rd_valid` for one cycle, and decrements the counter.
- On the last beat, state goes to IDLE and `done` is registered coincident with the last `rd_valid`.
- `avm_m0_readdatavalid` outside RD_DATA is ignored.

**Reset**
- Reset mid-command aborts immediately; the FSM returns to IDLE.
- Late read beats from an aborted burst are dropped. Callers must not reissue until the slave has drained.

## Timing
- Reset values:
  - All `avm_m0_*` outputs 0.
  - `cmd_ready` 1.
  - `wr_ready`, `rd_valid`, `done`, `busy` 0.
  - `rd_data` 0.
- Write latency: `avm_m0_write` can be high the cycle after accept. With no stalls, N beats take N cycles, and `done` pulses at accept + N + 1.
- Read latency:
  - `avm_m0_read` is high the cycle after accept.
  - `rd_valid` follows each `avm_m0_readdatavalid` by exactly 1 cycle.
  - `done` coincides with the final `rd_valid`.
- Back-to-back commands: after `done`, the next command can be accepted in the same cycle that `done` is high.
- `busy` is registered: it goes high the cycle after accept and low the cycle `done` is high.

## Test plan
- **Single-beat write, no wait.** Write, address 0x100, len 1, data 0xA5…A5. Expect one cycle of `avm_m0_write` with burstcount 1 and address 0x100, then `done` 2 cycles after accept.
- **Eight-beat write with stalls.** Write, len 8, with waitrequest high on beats 3–5 and a `wr_valid` gap after beat 6. Expect:
  - exactly 8 transfers, in order;
  - address and burstcount (8) stable throughout;
  - `wr_ready` low while stalled.
- **Four-beat read with latency.** Read, len 4, waitrequest high for 3 cycles, then readdatavalid with 2-cycle gaps. Expect:
  - `avm_m0_read` deasserts after the grant;
  - 4 `rd_valid` pulses each 1 cycle after readdatavalid, with matching data;
  - `done` on the 4th pulse.
- **Zero and oversize lengths.** `cmd_len` = 0 → no `avm_m0_read`/`avm_m0_write`, and `done` the next cycle. `cmd_len` = 100 with `MAX_BURST` = 64 → burstcount 64.
- **Reset mid-read.** Assert reset after 2 of 8 read beats. Expect all outputs at reset values the next cycle, `cmd_ready` = 1, and no `rd_valid` from the remaining beats.
- **Back-to-back commands.** Write len 2, then read len 2 offered in the same cycle as write `done`. The read must be accepted that cycle, and `busy` must have no idle gap of more than 1 cycle.
